alu_share_arb: RTL and testbench

//  Shares one combinational ALU between two requesters (req0 = core execute, req1 = address/aux unit).

---
 rtl/alu_share_arb_pkg.sv | 17 +
 rtl/alu_share_arb_rr_pick2.sv | 16 +
 rtl/alu_share_arb.sv | 120 ++++++++++++
 tb/tb_alu_share_arb.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the two-requester ALU sharing arbiter.
// Entry state encodings and the captured ALU result bundle.
package alu_share_arb_pkg;

    localparam int ALU_ARB_REQ_N = 2;
    localparam int ALU_W = 32;
    localparam int OP_W = 4;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic             zero;
    } alu_cap_t;

endpackage

// File: rtl/alu_share_arb_rr_pick2.sv
// Two-way round-robin picker: when both are valid, the one that was
// not granted last wins; a lone valid always wins.
module rr_pick2 (
    input  logic v0,
    input  logic v1,
    input  logic last,
    output logic g0,
    output logic g1
);

    always_comb begin
        g0 = v0 & (~v1 | last);
        g1 = v1 & (~v0 | ~last);
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two valid/ready requesters,
// returning each result through a single-entry response register.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int FIRST_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,

    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero
);

    localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    logic             st_q, st_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    alu_cap_t         cap_q, cap_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic                     own_rdy;
    logic                     free;
    logic                     accept;
    logic [ALU_ARB_REQ_N-1:0] grant;

    // The slot frees up in the same cycle its owner drains it.
    assign own_rdy = owner_q ? rsp1_ready : rsp0_ready;
    assign free    = (st_q == ST_EMPTY) | own_rdy;

    rr_pick2 u_pick (
        .v0   (req0_valid & free & rst_n),
        .v1   (req1_valid & free & rst_n),
        .last (last_q),
        .g0   (grant[0]),
        .g1   (grant[1])
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;

    // Idle selects req0 so the ALU inputs do not toggle needlessly.
    always_comb begin
        alu_a    = req0_a;
        alu_b    = req0_b;
        alu_ctrl = req0_op;
        if (grant[1]) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_op;
        end
    end

    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        last_d  = last_q;
        cap_d   = cap_q;
        tag_d   = tag_q;
        if (!rst_n) begin
            st_d    = ST_EMPTY;
            owner_d = 1'b0;
            last_d  = LAST_RST;
            cap_d   = '0;
            tag_d   = '0;
        end else if (accept) begin
            st_d         = ST_FULL;
            owner_d      = grant[1];
            last_d       = grant[1];
            cap_d.result = alu_result;
            cap_d.zero   = alu_zero;
            tag_d        = grant[1] ? req1_tag : req0_tag;
        end else if (free) begin
            st_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        st_q    <= st_d;
        owner_q <= owner_d;
        last_q  <= last_d;
        cap_q   <= cap_d;
        tag_q   <= tag_d;
    end

    assign rsp0_valid = rst_n & (st_q == ST_FULL) & ~owner_q;
    assign rsp1_valid = rst_n & (st_q == ST_FULL) & owner_q;
    assign rsp_result = cap_q.result;
    assign rsp_zero   = cap_q.zero;
    assign rsp_tag    = tag_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus random traffic,
// checked against a cycle-level model of the sharing rules.
module tb_alu_share_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        r_valid [2];
    logic [3:0]  r_op    [2];
    logic [31:0] r_a     [2];
    logic [31:0] r_b     [2];
    logic [3:0]  r_tag   [2];
    logic        rsp_rdy [2];

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero;
    logic [31:0] rsp_result, alu_a, alu_b, alu_result;
    logic [3:0]  rsp_tag, alu_ctrl;
    logic        alu_zero;

    int total = 0;
    int bad = 0;

    function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    assign alu_zero   = (alu_result == 32'd0);

    alu_share_arb #(.TAG_W(4), .FIRST_PRIO(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (r_valid[0]),
        .req0_ready (req0_ready),
        .req0_op    (r_op[0]),
        .req0_a     (r_a[0]),
        .req0_b     (r_b[0]),
        .req0_tag   (r_tag[0]),
        .req1_valid (r_valid[1]),
        .req1_ready (req1_ready),
        .req1_op    (r_op[1]),
        .req1_a     (r_a[1]),
        .req1_b     (r_b[1]),
        .req1_tag   (r_tag[1]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp_rdy[0]),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp_rdy[1]),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_tag    (rsp_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    // Model: one response slot, who owns it, who was served last.
    logic        m_full;
    int          m_owner;
    int          m_last;
    logic [31:0] m_res;
    logic        m_zero;
    logic [3:0]  m_tag;
    int          last_g;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full  = 1'b0;
        m_owner = 0;
        m_last  = 1;
        m_res   = '0;
        m_zero  = 1'b0;
        m_tag   = '0;
    endtask

    task automatic step();
        int   g;
        logic fr;
        #4;
        fr = !m_full || rsp_rdy[m_owner];
        g = -1;
        if (rst_n && fr) begin
            if (r_valid[0] && r_valid[1]) g = (m_last == 0) ? 1 : 0;
            else if (r_valid[0]) g = 0;
            else if (r_valid[1]) g = 1;
        end
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("rsp0_valid", rsp0_valid, rst_n && m_full && m_owner == 0);
        chk("rsp1_valid", rsp1_valid, rst_n && m_full && m_owner == 1);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_zero", rsp_zero, m_zero);
        chk("rsp_tag", rsp_tag, m_tag);
        if (g >= 0) begin
            chk("alu_a", alu_a, r_a[g]);
            chk("alu_b", alu_b, r_b[g]);
            chk("alu_ctrl", alu_ctrl, r_op[g]);
        end else begin
            chk("alu_a_idle", alu_a, r_a[0]);
        end
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            m_full  = 1'b1;
            m_owner = g;
            m_last  = g;
            m_res   = alu_fn(r_op[g], r_a[g], r_b[g]);
            m_zero  = (m_res == 32'd0);
            m_tag   = r_tag[g];
        end else if (fr) begin
            m_full = 1'b0;
        end
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        r_valid[n] = v;
        r_op[n]    = op;
        r_a[n]     = a;
        r_b[n]     = b;
        r_tag[n]   = t;
    endtask

    initial begin
        logic [31:0] held_res;
        logic [3:0]  held_tag;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        rsp_rdy[0] = 1'b1;
        rsp_rdy[1] = 1'b1;
        model_reset();
        last_g = -1;
        @(posedge clk);
        #1;

        // 1: reset held with a pending request
        r_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t1_rsp_result", rsp_result, 32'd0);

        // 2: single ADD
        rst_n = 1'b1;
        set_req(0, 1'b1, 4'b0010, 32'd5, 32'd7, 4'd3);
        step();
        r_valid[0] = 1'b0;
        chk("t2_valid", rsp0_valid, 1'b1);
        chk("t2_result", rsp_result, 32'd12);
        chk("t2_zero", rsp_zero, 1'b0);
        chk("t2_tag", rsp_tag, 4'd3);
        step();

        // 3: contention after a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(0, 1'b1, 4'b0010, 32'd1, 32'd2, 4'd1);
        set_req(1, 1'b1, 4'b0110, 32'd9, 32'd9, 4'd2);
        for (int i = 0; i < 6; i++) begin
            step();
            if (i % 2 == 1) begin
                chk("t3_rsp1_valid", rsp1_valid, 1'b1);
                chk("t3_result", rsp_result, 32'd0);
                chk("t3_zero", rsp_zero, 1'b1);
            end else begin
                chk("t3_rsp0_valid", rsp0_valid, 1'b1);
            end
        end

        // 4: owner backpressure stalls the other requester
        set_req(1, 1'b0, 4'b0110, 32'd9, 32'd9, 4'd2);
        set_req(0, 1'b1, 4'b0001, 32'h30, 32'h0c, 4'd6);
        rsp_rdy[0] = 1'b0;
        step();
        r_valid[0] = 1'b0;
        set_req(1, 1'b1, 4'b0110, 32'd20, 32'd3, 4'd9);
        held_res = rsp_result;
        held_tag = rsp_tag;
        chk("t4_first_res", held_res, 32'h3c);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_hold_res", rsp_result, held_res);
            chk("t4_hold_tag", rsp_tag, held_tag);
            chk("t4_hold_valid", rsp0_valid, 1'b1);
        end
        rsp_rdy[0] = 1'b1;
        step();
        r_valid[1] = 1'b0;
        chk("t4_rsp1_valid", rsp1_valid, 1'b1);
        chk("t4_result", rsp_result, 32'd17);

        // 5: reset right after an accept discards it
        step();
        set_req(1, 1'b1, 4'b0111, 32'hffff_ffff, 32'd1, 4'd5);
        step();
        r_valid[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rsp1_now", rsp1_valid, 1'b0);
        step();
        chk("t5_rsp1_a", rsp1_valid, 1'b0);
        rst_n = 1'b1;
        step();
        chk("t5_rsp1_b", rsp1_valid, 1'b0);

        // 6: back-to-back ADDs
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1'b1, 4'b0010, 32'(k), 32'd100, 4'(k));
            step();
            chk("t6_valid", rsp0_valid, 1'b1);
            chk("t6_tag", rsp_tag, 4'(k));
            chk("t6_result", rsp_result, 32'(k + 100));
        end
        r_valid[0] = 1'b0;
        step();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!(r_valid[n] && last_g != n)) begin
                    r_valid[n] = ($urandom_range(0, 2) != 0);
                    r_op[n]    = 4'($urandom_range(0, 15));
                    r_a[n]     = $urandom;
                    r_b[n]     = ($urandom_range(0, 3) == 0) ? r_a[n] : $urandom;
                    r_tag[n]   = 4'($urandom_range(0, 15));
                end
                rsp_rdy[n] = ($urandom_range(0, 4) != 0);
            end
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
